// File: rtl/adder_tree_acc.sv
// Pipelined, valid-tagged adder tree that reduces IDIM lanes per beat and
// accumulates successive tree sums into one wide result per group.
module adder_tree_acc #(
    parameter int IDIM   = 128,
    parameter int IWID   = 1,
    parameter int SIGNED = 0,
    parameter int BDEP   = 2,
    parameter int ACCW   = 8,
    parameter int CNTW   = 8,
    parameter int IDL2   = $clog2(IDIM),
    parameter int TWID   = IWID + IDL2,
    parameter int OWID   = TWID + ACCW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic            i_last,
    input  logic [IWID-1:0] iData [IDIM],
    output logic            o_valid,
    output logic [OWID-1:0] o_data,
    output logic [CNTW-1:0] o_beats,
    output logic            o_ovf
);

    localparam int NPAD = 1 << IDL2;

    // Level k holds NPAD>>k partial sums plus the valid/last tag travelling with them.
    for (genvar k = 0; k <= IDL2; k++) begin : lvl
        localparam int N = NPAD >> k;
        logic [TWID-1:0] node [N];
        logic            v;
        logic            l;

        if (k == 0) begin : g_in
            for (genvar j = 0; j < NPAD; j++) begin : g_lane
                if (j < IDIM) begin : g_real
                    if (SIGNED != 0) begin : g_sx
                        assign node[j] = {{IDL2{iData[j][IWID-1]}}, iData[j]};
                    end else begin : g_zx
                        assign node[j] = {{IDL2{1'b0}}, iData[j]};
                    end
                end else begin : g_pad
                    assign node[j] = '0;
                end
            end
            assign v = i_valid;
            assign l = i_valid & i_last;
        end else if ((k % BDEP) == 0) begin : g_reg
            for (genvar j = 0; j < N; j++) begin : g_add
                always_ff @(posedge clk) begin
                    if (rst) begin
                        node[j] <= '0;
                    end else begin
                        node[j] <= lvl[k-1].node[2*j] + lvl[k-1].node[2*j+1];
                    end
                end
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= 1'b0;
                    l <= 1'b0;
                end else begin
                    v <= lvl[k-1].v;
                    l <= lvl[k-1].l;
                end
            end
        end else begin : g_comb
            for (genvar j = 0; j < N; j++) begin : g_add
                assign node[j] = lvl[k-1].node[2*j] + lvl[k-1].node[2*j+1];
            end
            assign v = lvl[k-1].v;
            assign l = lvl[k-1].l;
        end
    end

    logic [TWID-1:0] top_sum;
    logic            top_v;
    logic            top_l;

    assign top_sum = lvl[IDL2].node[0];
    assign top_v   = lvl[IDL2].v;
    assign top_l   = lvl[IDL2].l;

    logic [OWID-1:0] sum_ext;
    logic [OWID-1:0] acc;
    logic [OWID-1:0] acc_add;
    logic [OWID-1:0] acc_next;
    logic            acc_carry;
    logic            acc_wrap;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_next;
    logic            cnt_wrap;
    logic            ovf;
    logic            ovf_next;
    logic            in_group;

    assign sum_ext = (SIGNED != 0) ? {{ACCW{top_sum[TWID-1]}}, top_sum}
                                   : {{ACCW{1'b0}}, top_sum};
    assign {acc_carry, acc_add} = {1'b0, acc} + {1'b0, sum_ext};

    // Signed wrap: operands agree in sign but the result does not.
    assign acc_wrap = (SIGNED != 0)
                    ? ((acc[OWID-1] == sum_ext[OWID-1]) && (acc_add[OWID-1] != acc[OWID-1]))
                    : acc_carry;
    assign cnt_wrap = &cnt;

    always_comb begin
        acc_next = acc_add;
        cnt_next = cnt + CNTW'(1);
        ovf_next = ovf | acc_wrap | cnt_wrap;
        if (!in_group) begin
            acc_next = sum_ext;
            cnt_next = CNTW'(1);
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            in_group <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_beats  <= '0;
            o_ovf    <= 1'b0;
        end else begin
            o_valid <= top_v & top_l;
            if (top_v) begin
                acc      <= acc_next;
                cnt      <= cnt_next;
                ovf      <= ovf_next;
                in_group <= !top_l;
                if (top_l) begin
                    o_data  <= acc_next;
                    o_beats <= cnt_next;
                    o_ovf   <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc: three configurations (default unsigned,
// small signed, narrow overflow-prone) share clock and reset.
module tb_adder_tree_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Configuration 0: defaults (IDIM=128, IWID=1), latency 4, OWID 16
    logic       v0, l0;
    logic [0:0] in0 [128];
    logic       ov0;
    logic [15:0] od0;
    logic [7:0] ob0;
    logic       of0;

    // Configuration 1: IDIM=4, IWID=4, signed, BDEP=1, latency 3, OWID 14
    logic       v1, l1;
    logic [3:0] in1 [4];
    logic       ov1;
    logic [13:0] od1;
    logic [7:0] ob1;
    logic       of1;

    // Configuration 2: IDIM=2, IWID=4, ACCW=1, latency 1, OWID 6
    logic       v2, l2;
    logic [3:0] in2 [2];
    logic       ov2;
    logic [5:0] od2;
    logic [7:0] ob2;
    logic       of2;

    adder_tree_acc dut0 (
        .clk(clk), .rst(rst), .i_valid(v0), .i_last(l0), .iData(in0),
        .o_valid(ov0), .o_data(od0), .o_beats(ob0), .o_ovf(of0)
    );

    adder_tree_acc #(.IDIM(4), .IWID(4), .SIGNED(1), .BDEP(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .i_last(l1), .iData(in1),
        .o_valid(ov1), .o_data(od1), .o_beats(ob1), .o_ovf(of1)
    );

    adder_tree_acc #(.IDIM(2), .IWID(4), .ACCW(1)) dut2 (
        .clk(clk), .rst(rst), .i_valid(v2), .i_last(l2), .iData(in2),
        .o_valid(ov2), .o_data(od2), .o_beats(ob2), .o_ovf(of2)
    );

    typedef struct {
        longint data;
        int     beats;
        bit     ovf;
        int     due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int OW  [3] = '{16, 14, 6};
    int LAT [3] = '{4, 3, 1};

    longint m_acc  [3];
    int     m_cnt  [3];
    bit     m_ovf  [3];
    bit     m_open [3];

    int lv [4];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: true arithmetic, folded back into range when it leaves it.
    task automatic modelBeat(input int d, input longint s, input bit last);
        longint ow;
        longint half;
        exp_t   e;
        ow   = longint'(1) << OW[d];
        half = ow / 2;
        if (!m_open[d]) begin
            m_acc[d] = 0;
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
        end
        m_acc[d] = m_acc[d] + s;
        if (d == 1) begin
            if (m_acc[d] > half - 1) begin
                m_acc[d] = m_acc[d] - ow;
                m_ovf[d] = 1'b1;
            end else if (m_acc[d] < -half) begin
                m_acc[d] = m_acc[d] + ow;
                m_ovf[d] = 1'b1;
            end
        end else if (m_acc[d] >= ow) begin
            m_acc[d] = m_acc[d] - ow;
            m_ovf[d] = 1'b1;
        end
        m_cnt[d] = m_cnt[d] + 1;
        if (m_cnt[d] == 256) begin
            m_cnt[d] = 0;
            m_ovf[d] = 1'b1;
        end
        m_open[d] = !last;
        if (last) begin
            e.data  = m_acc[d] & (ow - 1);
            e.beats = m_cnt[d];
            e.ovf   = m_ovf[d];
            e.due   = cycle + LAT[d];
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // Drives one cycle on configuration d (others idle); lanes come from lv, or ones for config 0.
    task automatic applyStimulus(input int d, input bit v, input bit l, input int ones);
        longint s;
        s = 0;
        v0 = 1'b0; l0 = 1'b0; v1 = 1'b0; l1 = 1'b0; v2 = 1'b0; l2 = 1'b0;
        for (int i = 0; i < 128; i++) in0[i] = 1'b0;
        for (int i = 0; i < 4; i++) in1[i] = 4'd0;
        for (int i = 0; i < 2; i++) in2[i] = 4'd0;
        case (d)
            0: begin
                v0 = v; l0 = l;
                for (int i = 0; i < 128; i++) in0[i] = 1'(i < ones);
                s = ones;
            end
            1: begin
                v1 = v; l1 = l;
                for (int i = 0; i < 4; i++) begin
                    in1[i] = lv[i][3:0];
                    s = s + lv[i];
                end
            end
            default: begin
                v2 = v; l2 = l;
                for (int i = 0; i < 2; i++) begin
                    in2[i] = lv[i][3:0];
                    s = s + lv[i];
                end
            end
        endcase
        if (v) modelBeat(d, s, l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 1'b0, 1'b0, 0);
    endtask

    task automatic checkPop(input int d, input longint data, input int beats, input bit ovf);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checkOutput($sformatf("cfg%0d unexpected o_valid", d), 1, 0);
        end else begin
            checkOutput($sformatf("cfg%0d o_data", d), data, e.data);
            checkOutput($sformatf("cfg%0d o_beats", d), beats, e.beats);
            checkOutput($sformatf("cfg%0d o_ovf", d), longint'(ovf), longint'(e.ovf));
            checkOutput($sformatf("cfg%0d latency cycle", d), cycle, e.due);
        end
    endtask

    always @(negedge clk) if (ov0) checkPop(0, longint'(od0), int'(ob0), of0);
    always @(negedge clk) if (ov1) checkPop(1, longint'(od1), int'(ob1), of1);
    always @(negedge clk) if (ov2) checkPop(2, longint'(od2), int'(ob2), of2);

    initial begin
        for (int d = 0; d < 3; d++) m_open[d] = 1'b0;
        lv = '{0, 0, 0, 0};
        rst = 1'b1;
        v0 = 1'b0; l0 = 1'b0; v1 = 1'b0; l1 = 1'b0; v2 = 1'b0; l2 = 1'b0;
        for (int i = 0; i < 128; i++) in0[i] = 1'b0;
        for (int i = 0; i < 4; i++) in1[i] = 4'd0;
        for (int i = 0; i < 2; i++) in2[i] = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1'b0, 1'b0, 0);
            checkOutput("idle o_valid", longint'(ov0 | ov1 | ov2), 0);
        end
        checkOutput("idle o_data", longint'(od0), 0);
        checkOutput("idle o_beats", longint'(ob0), 0);
        checkOutput("idle o_ovf", longint'(of0 | of1 | of2), 0);

        $display("[TB] single beat all ones");
        applyStimulus(0, 1'b1, 1'b1, 128);
        idle(6);

        $display("[TB] multi-beat with gap and stray last");
        applyStimulus(0, 1'b1, 1'b0, 5);
        applyStimulus(0, 1'b1, 1'b0, 17);
        applyStimulus(0, 1'b0, 1'b1, 128);
        applyStimulus(0, 1'b1, 1'b1, 128);
        idle(6);
        checkOutput("hold o_data", longint'(od0), 150);

        $display("[TB] signed mode");
        lv = '{-8, -8, 3, 1};
        applyStimulus(1, 1'b1, 1'b0, 0);
        lv = '{7, 7, 7, 7};
        applyStimulus(1, 1'b1, 1'b1, 0);
        idle(5);

        $display("[TB] accumulator overflow");
        lv = '{15, 15, 0, 0};
        applyStimulus(2, 1'b1, 1'b0, 0);
        applyStimulus(2, 1'b1, 1'b0, 0);
        applyStimulus(2, 1'b1, 1'b1, 0);
        lv = '{1, 2, 0, 0};
        applyStimulus(2, 1'b1, 1'b1, 0);
        idle(3);

        $display("[TB] beat counter wrap");
        lv = '{0, 0, 0, 0};
        for (int i = 0; i < 260; i++) applyStimulus(2, 1'b1, 1'b0, 0);
        lv = '{1, 0, 0, 0};
        applyStimulus(2, 1'b1, 1'b1, 0);
        idle(3);

        $display("[TB] reset mid-group then back-to-back");
        applyStimulus(0, 1'b1, 1'b0, 50);
        applyStimulus(0, 1'b1, 1'b0, 60);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) m_open[d] = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 0);
        rst = 1'b0;
        checkOutput("post-reset o_data", longint'(od0), 0);
        applyStimulus(0, 1'b1, 1'b1, 10);
        applyStimulus(0, 1'b1, 1'b1, 20);
        idle(6);

        $display("[TB] random groups");
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++) lv[k] = int'($urandom_range(15)) - 8;
            applyStimulus(1, 1'($urandom_range(3) != 0), 1'($urandom_range(2) == 0), 0);
        end
        applyStimulus(1, 1'b1, 1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++) lv[k] = int'($urandom_range(15));
            applyStimulus(2, 1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0), 0);
        end
        applyStimulus(2, 1'b1, 1'b1, 0);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(0, 1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0),
                          int'($urandom_range(128)));
        end
        applyStimulus(0, 1'b1, 1'b1, 77);

        for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) > 0; i++) idle(1);
        checkOutput("cfg0 pending results", q0.size(), 0);
        checkOutput("cfg1 pending results", q1.size(), 0);
        checkOutput("cfg2 pending results", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
